mod_counter: RTL

Parametrised synchronous modulo counter, the clocked successor of the free-running 5-bit behavioural counter. It adds a programmable terminal value, enable, synchronous clear and load, and three end-of-range modes: wrap, saturate and one-shot. It is used as a general event or period counter wherever a clocked, resettable count with terminal-count indication is needed.

---
 rtl/mod_counter_pkg.sv | 15 +
 rtl/mod_counter_next.sv | 59 +++++
 rtl/mod_counter.sv | 84 ++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for mod_counter: end-of-range mode encodings and a mode helper.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    // Encoding 2'b11 is not a distinct mode and behaves exactly like wrap.
    function automatic logic is_wrap_mode(input logic [1:0] m);
        return (m != MODE_SAT) && (m != MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-state step for mod_counter: one enabled count step, terminal detect,
// wrap strobe and one-shot done-set strobe. Down counting exists only with MOD_COUNTER_UPDOWN_EN.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [1:0]       i_mode,
`ifdef MOD_COUNTER_UPDOWN_EN
    input  logic             i_up,
`endif
    input  logic             i_done,
    output logic [WIDTH-1:0] o_next,
    output logic             o_at_term,
    output logic             o_wrap,
    output logic             o_done_set
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_reload;
    logic [WIDTH-1:0] w_step;
    logic             w_at_term;

`ifdef MOD_COUNTER_UPDOWN_EN
    assign w_term   = i_up ? MAX_W : '0;
    assign w_reload = i_up ? '0 : MAX_W;
    assign w_step   = i_up ? (i_count + ONE_W) : (i_count - ONE_W);
`else
    assign w_term   = MAX_W;
    assign w_reload = '0;
    assign w_step   = i_count + ONE_W;
`endif

    assign w_at_term = (i_count == w_term);
    assign o_at_term = w_at_term;

    // A finished one-shot ignores enable entirely; only clr/load in the top re-arm it.
    always_comb begin
        o_next     = i_count;
        o_wrap     = 1'b0;
        o_done_set = 1'b0;
        if (!i_done) begin
            if (!w_at_term) begin
                o_next = w_step;
            end else if (is_wrap_mode(i_mode)) begin
                o_next = w_reload;
                o_wrap = 1'b1;
            end else if (i_mode == MODE_ONESHOT) begin
                o_done_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter with wrap/saturate/one-shot end-of-range modes, clear, load
// and terminal-count flag. Define MOD_COUNTER_UPDOWN_EN to add the up port and down counting.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MAX     = 2**WIDTH-1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
`ifdef MOD_COUNTER_UPDOWN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] Count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;

    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamp;
    logic             w_at_term;
    logic             w_wrap_step;
    logic             w_done_set;

    assign w_load_clamp = (load_val > MAX_W) ? MAX_W : load_val;

    mod_counter_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_next (
        .i_count    (r_count),
        .i_mode     (mode),
`ifdef MOD_COUNTER_UPDOWN_EN
        .i_up       (up),
`endif
        .i_done     (r_done),
        .o_next     (w_next),
        .o_at_term  (w_at_term),
        .o_wrap     (w_wrap_step),
        .o_done_set (w_done_set)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL_W;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamp;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (en) begin
            r_count <= w_next;
            r_wrap  <= w_wrap_step;
            r_done  <= r_done | w_done_set;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign Count = r_count;
    assign tc    = w_at_term;
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule
